// File: rtl/pa_fadd_align_arb_if.sv
// Request, shifter and response signals between the alignment-shifter arbiter and its neighbours.
// slave = arbiter side; master = requesters, external shifter and result consumer.
interface pa_fadd_align_arb_if;
  logic        req0_vld;
  logic [23:0] req0_data;
  logic [7:0]  req0_cnt;
  logic        req0_rdy;
  logic        req1_vld;
  logic [23:0] req1_data;
  logic [7:0]  req1_cnt;
  logic        req1_rdy;
  logic [23:0] shf_data_in;
  logic [7:0]  shf_cnt;
  logic [23:0] shf_data_out;
  logic        shf_g;
  logic        shf_r;
  logic        shf_s;
  logic        rsp_vld;
  logic        rsp_id;
  logic [23:0] rsp_data;
  logic        rsp_g;
  logic        rsp_r;
  logic        rsp_s;
  logic        rsp_rdy;

  modport slave (
    input  req0_vld, req0_data, req0_cnt, req1_vld, req1_data, req1_cnt,
    input  shf_data_out, shf_g, shf_r, shf_s, rsp_rdy,
    output req0_rdy, req1_rdy, shf_data_in, shf_cnt,
    output rsp_vld, rsp_id, rsp_data, rsp_g, rsp_r, rsp_s
  );

  modport master (
    output req0_vld, req0_data, req0_cnt, req1_vld, req1_data, req1_cnt,
    output shf_data_out, shf_g, shf_r, shf_s, rsp_rdy,
    input  req0_rdy, req1_rdy, shf_data_in, shf_cnt,
    input  rsp_vld, rsp_id, rsp_data, rsp_g, rsp_r, rsp_s
  );
endinterface

// File: rtl/pa_fadd_align_arb.sv
// Two-requester arbiter for a shared single-precision alignment shifter with a one-entry result slot.
// Optional req1 anti-starvation: define PA_FADD_ALIGN_ARB_STARVE_EN.
module pa_fadd_align_arb #(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 3
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  pa_fadd_align_arb_if.slave arb
);

  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_id_q,  rsp_id_d;
  logic [23:0] rsp_data_q, rsp_data_d;
  logic        rsp_g_q, rsp_g_d;
  logic        rsp_r_q, rsp_r_d;
  logic        rsp_s_q, rsp_s_d;
  logic        slot_free, force1, gnt0, gnt1;

  // Drain and refill of the single slot may happen in the same cycle.
  assign slot_free = !rsp_vld_q | arb.rsp_rdy;
  assign gnt1      = slot_free & arb.req1_vld & (!arb.req0_vld | force1);
  assign gnt0      = slot_free & arb.req0_vld & !gnt1;

  assign arb.req0_rdy = gnt0;
  assign arb.req1_rdy = gnt1;

`ifdef PA_FADD_ALIGN_ARB_STARVE_EN
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force1 = (starve_cnt_q == CNT_W'(STARVE_LIM));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt1 || !arb.req1_vld)
      starve_cnt_d = '0;
    else if (slot_free && gnt0)
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{CNT_W[0], STARVE_LIM[0]};
  assign force1     = 1'b0;
`endif

  // Idle shifter inputs are forced to zero so the datapath does not toggle.
  always_comb begin
    arb.shf_data_in = '0;
    arb.shf_cnt     = '0;
    if (gnt0) begin
      arb.shf_data_in = arb.req0_data;
      arb.shf_cnt     = arb.req0_cnt;
    end else if (gnt1) begin
      arb.shf_data_in = arb.req1_data;
      arb.shf_cnt     = arb.req1_cnt;
    end
  end

  always_comb begin
    rsp_vld_d  = rsp_vld_q & !arb.rsp_rdy;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_g_d    = rsp_g_q;
    rsp_r_d    = rsp_r_q;
    rsp_s_d    = rsp_s_q;
    if (gnt0 || gnt1) begin
      rsp_vld_d  = 1'b1;
      rsp_id_d   = gnt1;
      rsp_data_d = arb.shf_data_out;
      rsp_g_d    = arb.shf_g;
      rsp_r_d    = arb.shf_r;
      rsp_s_d    = arb.shf_s;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_g_q    <= 1'b0;
      rsp_r_q    <= 1'b0;
      rsp_s_q    <= 1'b0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_g_q    <= rsp_g_d;
      rsp_r_q    <= rsp_r_d;
      rsp_s_q    <= rsp_s_d;
    end
  end

  assign arb.rsp_vld  = rsp_vld_q;
  assign arb.rsp_id   = rsp_id_q;
  assign arb.rsp_data = rsp_data_q;
  assign arb.rsp_g    = rsp_g_q;
  assign arb.rsp_r    = rsp_r_q;
  assign arb.rsp_s    = rsp_s_q;

endmodule
